arm_alu_commit_syn: RTL and testbench
=====================================

Name: arm_alu_commit_syn

Overview:
Downstream commit stage for the 4-bit ARM-style ALU datapath. Accepts each ALU result and NZCV flags with a valid/ready handshake and holds them in one pending slot. One cycle later it evaluates the ARM condition code against the architectural CPSR, then writes the 8-entry register file and updates the CPSR. It also forwards operands and the next CPSR (including C for ADC/SBC/RSC) back to the ALU operand stage.

Parameters:
NREGS, 8, register-file entries (index width 3)
DW, 4, datapath width, matching the ALU result width
CNTW, 8, width of the retire and annul counters

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
freeze  input  1  global stall; no capture, no commit
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept; equals ~freeze
in_op  input  4  ALU opcode (AND..MVN encoding)
in_cond  input  4  ARM condition field
in_s  input  1  S bit (set flags)
in_rd  input  3  destination register
in_result  input  DW  ALU alu_out
in_flags  input  4  ALU cpsr_out {N,Z,C,V}
rs1_addr, rs2_addr  input  3  operand read addresses
rs1_data, rs2_data  output  DW  forwarded operand data, combinational
cpsr  output  4  architectural {N,Z,C,V}
cpsr_fwd  output  4  CPSR value after the pending commit, combinational; feeds ALU carry-in
wb_valid  output  1  registered pulse: a register write happened this cycle
wb_rd  output  3  register written
wb_data  output  DW  value written
retire_cnt  output  CNTW  committed instructions with condition passed, wraps
annul_cnt  output  CNTW  committed instructions with condition failed, wraps

Behaviour:
- Reset (async, rst_n=0): all registers 0, cpsr=0, pending slot invalid, wb_valid=0, wb_rd=0, wb_data=0, both counters 0. Reset mid-operation discards the pending entry with no commit.
- Handshake: accept when in_valid & in_ready. The pending slot loads op/cond/s/rd/result/flags.
- Each cycle with freeze=0:
  - If the pending slot is valid, commit it.
  - The slot then loads the new input if one is accepted; otherwise it becomes invalid.
  - Throughput is 1 per cycle; accept-to-commit latency is 1 cycle.
- freeze=1: slot, regfile, cpsr and counters all hold; wb_valid=0.
- Condition pass is evaluated at commit against cpsr, standard ARM codes:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 never
- Passed commit:
  - retire_cnt+1.
  - Writes rd unless op ∈ {TST,TEQ,CMP,CMN}. On a write: wb_valid=1, wb_rd, wb_data updated next edge.
  - Flag update happens if in_s=1, or always for TST/TEQ/CMP/CMN.
  - Arithmetic ops (SUB,RSB,ADD,ADC,SBC,RSC,CMP,CMN) update all NZCV.
  - Logical ops update N,Z only; C,V hold.
- Failed commit: annul_cnt+1, no register write, no flag change, wb_valid=0.
- Back-to-back: the second instruction's condition sees CPSR as updated by the first (first commits on the edge before).
- Read forwarding: rsN_data = pending result if the slot is valid, the condition passes, it writes, and rd==rsN_addr; otherwise the regfile value. Both ports may hit the same entry.
- cpsr_fwd = cpsr with the pending flag update applied if it will pass and update; otherwise cpsr.
- Counters wrap 2^CNTW-1 → 0.

Test Plan:
1. Reset, then ADD S=1 AL rd=2 result=4'h0 flags=4'b0110 → next cycle r2=0, cpsr=0110, wb_valid=1, wb_rd=2, retire_cnt=1.
2. CMP AL flags=4'b0100 (Z) followed immediately by MOV EQ rd=3 result=4'h9 → r3=9; repeat with NE → r3 unchanged, annul_cnt+1, wb_valid=0.
3. cpsr=1011, AND S=1 result=4'h0 flags=0100 → cpsr=0111 (C,V kept); TST → no write, flags still updated.
4. Pending ADC S=1 rd=5 result=7 flags=0010 while rs1_addr=5 → rs1_data=7 and cpsr_fwd[C]=1 in the same cycle; with cond failing → old r5, cpsr_fwd=cpsr.
5. freeze=1 for 3 cycles with the slot full → in_ready=0, no commit, state unchanged; release → commit on the first free cycle; assert rst_n=0 mid-freeze → slot dropped, all zero.
6. 256 passed commits → retire_cnt wraps to 0; cond=1111 → annul only.

Source files
------------

// File: rtl/arm_alu_commit_syn.sv
// Commit stage for the 4-bit ARM-style ALU: one pending slot, condition check
// against the architectural CPSR, register-file write-back and operand/CPSR forwarding.
module arm_alu_commit_syn #(
  parameter int NREGS = 8,
  parameter int DW    = 4,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [3:0]      in_cond,
  input  logic            in_s,
  input  logic [2:0]      in_rd,
  input  logic [DW-1:0]   in_result,
  input  logic [3:0]      in_flags,
  input  logic [2:0]      rs1_addr,
  input  logic [2:0]      rs2_addr,
  output logic [DW-1:0]   rs1_data,
  output logic [DW-1:0]   rs2_data,
  output logic [3:0]      cpsr,
  output logic [3:0]      cpsr_fwd,
  output logic            wb_valid,
  output logic [2:0]      wb_rd,
  output logic [DW-1:0]   wb_data,
  output logic [CNTW-1:0] retire_cnt,
  output logic [CNTW-1:0] annul_cnt
);

  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } op_e;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  // Pending slot
  logic          p_valid;
  op_e           p_op;
  cond_e         p_cond;
  logic          p_s;
  logic [2:0]    p_rd;
  logic [DW-1:0] p_result;
  logic [3:0]    p_flags;

  logic [DW-1:0] regs [NREGS];

  logic n_f, z_f, c_f, v_f;
  logic cond_pass, is_test, is_arith;
  logic pass_fire, do_write, do_flags, commit;
  logic [3:0] new_flags;

  assign {n_f, z_f, c_f, v_f} = cpsr;
  assign in_ready = ~freeze;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cond_pass = 1'b0;
    unique case (p_cond)
      CC_EQ: cond_pass = z_f;
      CC_NE: cond_pass = ~z_f;
      CC_CS: cond_pass = c_f;
      CC_CC: cond_pass = ~c_f;
      CC_MI: cond_pass = n_f;
      CC_PL: cond_pass = ~n_f;
      CC_VS: cond_pass = v_f;
      CC_VC: cond_pass = ~v_f;
      CC_HI: cond_pass = c_f & ~z_f;
      CC_LS: cond_pass = ~c_f | z_f;
      CC_GE: cond_pass = (n_f == v_f);
      CC_LT: cond_pass = (n_f != v_f);
      CC_GT: cond_pass = ~z_f & (n_f == v_f);
      CC_LE: cond_pass = z_f | (n_f != v_f);
      CC_AL: cond_pass = 1'b1;
      CC_NV: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    is_arith = 1'b0;
    case (p_op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN: is_arith = 1'b1;
      default: is_arith = 1'b0;
    endcase
  end

  assign is_test   = (p_op == OP_TST) || (p_op == OP_TEQ) || (p_op == OP_CMP) || (p_op == OP_CMN);
  assign pass_fire = p_valid & cond_pass;
  assign do_write  = pass_fire & ~is_test;
  assign do_flags  = pass_fire & (p_s | is_test);
  assign commit    = p_valid & ~freeze;

  // Logical ops carry C and V over from the architectural CPSR.
  assign new_flags = is_arith ? p_flags : {p_flags[3:2], cpsr[1:0]};
  assign cpsr_fwd  = do_flags ? new_flags : cpsr;

  assign rs1_data = (do_write && p_rd == rs1_addr) ? p_result : regs[rs1_addr];
  assign rs2_data = (do_write && p_rd == rs2_addr) ? p_result : regs[rs2_addr];

  // NOTE: the register file is reset with the rest of the state; reset must clear every entry.
  // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid    <= 1'b0;
      p_op       <= OP_AND;
      p_cond     <= CC_EQ;
      p_s        <= 1'b0;
      p_rd       <= '0;
      p_result   <= '0;
      p_flags    <= '0;
      cpsr       <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      retire_cnt <= '0;
      annul_cnt  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (freeze) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      p_valid  <= in_valid;
      if (in_valid) begin
        p_op     <= op_e'(in_op);
        p_cond   <= cond_e'(in_cond);
        p_s      <= in_s;
        p_rd     <= in_rd;
        p_result <= in_result;
        p_flags  <= in_flags;
      end
      if (commit) begin
        if (cond_pass) begin
          retire_cnt <= retire_cnt + CNTW'(1);
          if (do_write) begin
            regs[p_rd] <= p_result;
            wb_valid   <= 1'b1;
            wb_rd      <= p_rd;
            wb_data    <= p_result;
          end
          if (do_flags) cpsr <= new_flags;
        end else begin
          annul_cnt <= annul_cnt + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_arm_alu_commit_syn.sv
// Scoreboard bench for arm_alu_commit_syn: a reference model predicts each commit
// at issue time and the expected write-back/CPSR/counter state is checked after the commit edge.
module tb_arm_alu_commit_syn;

  localparam int DW = 4, CNTW = 8, NREGS = 8;

  localparam logic [3:0] AND_ = 4'd0, ADD = 4'd4, ADC = 4'd5,
                         TST = 4'd8, CMP = 4'd10, MOV = 4'd13;
  localparam logic [3:0] EQ = 4'd0, NE = 4'd1, AL = 4'd14, NV = 4'd15;

  logic clk, rst_n, freeze, in_valid, in_ready, in_s, wb_valid;
  logic [3:0] in_op, in_cond, in_flags, cpsr, cpsr_fwd;
  logic [2:0] in_rd, rs1_addr, rs2_addr, wb_rd;
  logic [DW-1:0] in_result, rs1_data, rs2_data, wb_data;
  logic [CNTW-1:0] retire_cnt, annul_cnt;

  arm_alu_commit_syn #(.NREGS(NREGS), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_s(in_s), .in_rd(in_rd), .in_result(in_result),
    .in_flags(in_flags), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .cpsr(cpsr), .cpsr_fwd(cpsr_fwd), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .retire_cnt(retire_cnt), .annul_cnt(annul_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            wbv;
    logic [2:0]      rd;
    logic [DW-1:0]   data;
    logic [3:0]      cpsr;
    logic [CNTW-1:0] retire;
    logic [CNTW-1:0] annul;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (after every issued instruction)
  logic [DW-1:0]   m_regs [NREGS];
  logic [3:0]      m_cpsr;
  logic [CNTW-1:0] m_retire, m_annul;
  logic [2:0]      m_wb_rd;
  logic [DW-1:0]   m_wb_data;
  // Architectural state as of the last commit the bench has checked
  logic [3:0]      a_cpsr;
  logic [CNTW-1:0] a_retire, a_annul;
  logic            tb_pending;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_cpsr = '0; m_retire = '0; m_annul = '0; m_wb_rd = '0; m_wb_data = '0;
    a_cpsr = '0; a_retire = '0; a_annul = '0;
    tb_pending = 1'b0;
    exp_q.delete();
  endtask

  // One clock; pops and checks the expected commit if one was due on this edge.
  task automatic cycle();
    logic commit_now;
    exp_t e;
    commit_now = tb_pending && !freeze;
    @(posedge clk);
    #1;
    if (!freeze) tb_pending = in_valid;
    if (commit_now) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        a_cpsr = e.cpsr; a_retire = e.retire; a_annul = e.annul;
        check("wb_valid", {31'd0, wb_valid}, {31'd0, e.wbv});
        check("wb_rd", {29'd0, wb_rd}, {29'd0, e.rd});
        check("wb_data", {28'd0, wb_data}, {28'd0, e.data});
      end
    end else begin
      check("wb_valid_idle", {31'd0, wb_valid}, 32'd0);
    end
    check("cpsr", {28'd0, cpsr}, {28'd0, a_cpsr});
    check("retire_cnt", {24'd0, retire_cnt}, {24'd0, a_retire});
    check("annul_cnt", {24'd0, annul_cnt}, {24'd0, a_annul});
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                       input logic [2:0] rd, input logic [DW-1:0] res, input logic [3:0] fl);
    exp_t e;
    logic pass, wr, fu, arith;
    in_valid = 1'b1; in_op = op; in_cond = cond; in_s = s;
    in_rd = rd; in_result = res; in_flags = fl;
    if (!freeze) begin
      pass  = cond_ok(cond, m_cpsr);
      wr    = (op[3:2] != 2'b10);
      fu    = s || !wr;
      arith = (op >= 4'd2 && op <= 4'd7) || op == CMP || op == 4'd11;
      if (pass) begin
        m_retire = m_retire + 1'b1;
        if (wr) begin m_regs[rd] = res; m_wb_rd = rd; m_wb_data = res; end
        if (fu) m_cpsr = arith ? fl : {fl[3:2], m_cpsr[1:0]};
      end else begin
        m_annul = m_annul + 1'b1;
      end
      e.wbv = pass && wr; e.rd = m_wb_rd; e.data = m_wb_data;
      e.cpsr = m_cpsr; e.retire = m_retire; e.annul = m_annul;
      exp_q.push_back(e);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  // Combinational forwarding: the model already includes the (latest) pending instruction.
  task automatic fwd_check(input string tag);
    check({tag, "_rs1"}, {28'd0, rs1_data}, {28'd0, m_regs[rs1_addr]});
    check({tag, "_rs2"}, {28'd0, rs2_data}, {28'd0, m_regs[rs2_addr]});
    check({tag, "_cpsr_fwd"}, {28'd0, cpsr_fwd}, {28'd0, m_cpsr});
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0; in_valid = 1'b0; in_op = '0; in_cond = '0; in_s = 1'b0;
    in_rd = '0; in_result = '0; in_flags = '0; rs1_addr = '0; rs2_addr = '0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_cpsr", {28'd0, cpsr}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_retire", {24'd0, retire_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    fwd_check("rst");

    // 1: ADD S=1 AL into r2
    rs1_addr = 3'd2;
    issue(ADD, AL, 1'b1, 3'd2, 4'h0, 4'b0110);
    cycle();
    check("t1_cpsr", {28'd0, cpsr}, 32'b0110);
    check("t1_retire", {24'd0, retire_cnt}, 32'd1);
    fwd_check("t1");

    // 2: CMP sets Z, then MOV EQ / MOV NE back-to-back
    rs1_addr = 3'd3;
    issue(CMP, AL, 1'b0, 3'd0, 4'h0, 4'b0100);
    issue(MOV, EQ, 1'b0, 3'd3, 4'h9, 4'b0000);
    issue(CMP, AL, 1'b0, 3'd0, 4'h0, 4'b0100);
    issue(MOV, NE, 1'b0, 3'd3, 4'h5, 4'b0000);
    cycle();
    check("t2_r3", {28'd0, rs1_data}, 32'h9);
    fwd_check("t2");

    // 3: logical op keeps C,V; TST updates flags without a write
    rs1_addr = 3'd4; rs2_addr = 3'd1;
    issue(CMP, AL, 1'b0, 3'd0, 4'h0, 4'b1011);
    issue(AND_, AL, 1'b1, 3'd1, 4'h0, 4'b0100);
    issue(TST, AL, 1'b0, 3'd4, 4'hF, 4'b1000);
    cycle();
    check("t3_cpsr", {28'd0, cpsr}, 32'b1011);
    fwd_check("t3");

    // 4: forwarding from a pending ADC, then from a failing one
    rs1_addr = 3'd5; rs2_addr = 3'd5;
    issue(ADC, AL, 1'b1, 3'd5, 4'h7, 4'b0010);
    check("t4_rs1_fwd", {28'd0, rs1_data}, 32'h7);
    check("t4_cfwd_c", {31'd0, cpsr_fwd[1]}, 32'd1);
    fwd_check("t4a");
    issue(ADC, EQ, 1'b1, 3'd5, 4'h3, 4'b1111);
    check("t4_rs1_old", {28'd0, rs1_data}, 32'h7);
    check("t4_cfwd_hold", {28'd0, cpsr_fwd}, {28'd0, cpsr});
    cycle();

    // 5: freeze with slot full, release, then reset during freeze
    rs1_addr = 3'd6;
    issue(MOV, AL, 1'b1, 3'd6, 4'hA, 4'b1000);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_in_ready", {31'd0, in_ready}, 32'd0);
    end
    fwd_check("t5_frozen");
    freeze = 1'b0;
    cycle();
    fwd_check("t5_released");
    rs1_addr = 3'd7;
    issue(MOV, AL, 1'b0, 3'd7, 4'hC, 4'b0000);
    freeze = 1'b1;
    cycle();
    rst_n = 1'b0;
    #1;
    check("t5_rst_cpsr", {28'd0, cpsr}, 32'd0);
    check("t5_rst_retire", {24'd0, retire_cnt}, 32'd0);
    check("t5_rst_wbd", {28'd0, wb_data}, 32'd0);
    check("t5_rst_r7", {28'd0, rs1_data}, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    freeze = 1'b0;
    cycle();
    cycle();
    fwd_check("t5_after_rst");

    // 6: 256 passed commits wrap retire_cnt, then a never-condition annuls
    for (int i = 0; i < 256; i++)
      issue(MOV, AL, 1'b0, 3'(i), 4'(i), 4'b0000);
    cycle();
    check("t6_wrap", {24'd0, retire_cnt}, 32'd0);
    issue(MOV, NV, 1'b1, 3'd0, 4'hF, 4'b1111);
    cycle();
    check("t6_annul", {24'd0, annul_cnt}, 32'd1);

    // Every condition code against random flags, plus random mixed traffic
    for (int c = 0; c < 16; c++) begin
      rs1_addr = 3'd1; rs2_addr = 3'($urandom_range(0, 7));
      issue(CMP, AL, 1'b0, 3'd0, 4'h0, 4'($urandom));
      issue(MOV, 4'(c), 1'b0, 3'd1, 4'(c), 4'h0);
      fwd_check("cond");
    end
    for (int i = 0; i < 60; i++) begin
      rs1_addr = 3'($urandom); rs2_addr = 3'($urandom);
      issue(4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 4'($urandom), 4'($urandom));
      fwd_check("rand");
    end
    cycle();
    check("drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
